ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/ram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the byte-serialising RAM arbiter: FSM state, access-size
// encodings and the size-to-beat-count helper.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // The reserved size code 2'b11 is treated as a word.
  function automatic logic [2:0] beat_cnt(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: beat_cnt = 3'd1;
      SZ_HALF: beat_cnt = 3'd2;
      default: beat_cnt = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (instruction vs data) with a last-grant
// register; after reset the last grant reads as instruction, so data wins first.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_upd,
  output logic o_gnt_i,
  output logic o_gnt_d
);

  logic r_last_d;

  always_comb begin
    o_gnt_d = i_req_d & (~i_req_i | ~r_last_d);
    o_gnt_i = i_req_i & ~o_gnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last_d <= 1'b0;
    else if (i_upd & (o_gnt_i | o_gnt_d))
      r_last_d <= o_gnt_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates an instruction port and a data port onto a byte-wide RAM, moving
// one big-endian byte per cycle. Define ARB_MISALIGN_CHK_EN for alignment checks.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
`ifdef ARB_MISALIGN_CHK_EN
  output logic              d_err,
`endif
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  arb_state_e        r_state;
  logic              r_is_d;
  logic [1:0]        r_idx;
  logic [1:0]        r_lst;
  logic [DATA_W-1:0] r_wsh;
  logic [DATA_W-1:0] r_acc;
  logic              r_ram_en, r_ram_rw;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_wdata;
  logic              r_i_ack, r_d_ack;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;

  logic              w_gnt_i, w_gnt_d, w_any, w_upd, w_rw;
  logic [2:0]        w_nb;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wal, w_rd;

  assign w_any = i_req | d_req;
  assign w_upd = (r_state == IDLE) & w_any;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req_i (i_req),
    .i_req_d (d_req),
    .i_upd   (w_upd),
    .o_gnt_i (w_gnt_i),
    .o_gnt_d (w_gnt_d)
  );

  // Write data is left-justified so the first beat always takes the top byte.
  always_comb begin
    w_nb   = w_gnt_d ? beat_cnt(d_size) : 3'd4;
    w_addr = w_gnt_d ? d_addr : i_addr;
    w_rw   = w_gnt_d & d_rw;
    w_wal  = d_wdata << (DATA_W - 8 * int'(w_nb));
    w_rd   = {r_acc[DATA_W-9:0], ram_rdata};
  end

`ifdef ARB_MISALIGN_CHK_EN
  logic w_mis;
  logic r_d_err;

  always_comb begin
    if (w_gnt_d)
      w_mis = ((d_size == SZ_HALF) & d_addr[0]) | (d_size[1] & (d_addr[1:0] != 2'b00));
    else
      w_mis = (i_addr[1:0] != 2'b00);
  end

  assign d_err = r_d_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_is_d      <= 1'b0;
      r_idx       <= 2'd0;
      r_lst       <= 2'd0;
      r_wsh       <= '0;
      r_acc       <= '0;
      r_ram_en    <= 1'b0;
      r_ram_rw    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 8'h00;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
`ifdef ARB_MISALIGN_CHK_EN
      r_d_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_is_d <= w_gnt_d;
            r_idx  <= 2'd0;
            r_lst  <= w_nb[1:0] - 2'd1;
            r_acc  <= '0;
            r_wsh  <= w_wal << 8;
`ifdef ARB_MISALIGN_CHK_EN
            if (w_mis) begin
              // Rejected without touching the RAM; data result is left intact.
              r_state <= ACK;
              r_i_ack <= w_gnt_i;
              r_d_ack <= w_gnt_d;
              r_d_err <= w_gnt_d;
              if (w_gnt_i)
                r_i_rdata <= '0;
            end else
`endif
            begin
              r_state     <= BEAT;
              r_ram_en    <= 1'b1;
              r_ram_rw    <= w_rw;
              r_ram_addr  <= w_addr;
              r_ram_wdata <= w_rw ? w_wal[DATA_W-1 -: 8] : 8'h00;
            end
          end
        end
        BEAT: begin
          r_acc <= w_rd;
          if (r_idx == r_lst) begin
            r_state     <= ACK;
            r_ram_en    <= 1'b0;
            r_ram_rw    <= 1'b0;
            r_ram_wdata <= 8'h00;
            if (r_is_d) r_d_ack <= 1'b1;
            else        r_i_ack <= 1'b1;
            if (!r_ram_rw) begin
              if (r_is_d) r_d_rdata <= w_rd;
              else        r_i_rdata <= w_rd;
            end
          end else begin
            r_idx       <= r_idx + 2'd1;
            r_ram_addr  <= r_ram_addr + 1'b1;
            r_ram_wdata <= r_ram_rw ? r_wsh[DATA_W-1 -: 8] : 8'h00;
            r_wsh       <= r_wsh << 8;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_i_ack <= 1'b0;
          r_d_ack <= 1'b0;
`ifdef ARB_MISALIGN_CHK_EN
          r_d_err <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_rw    = r_ram_rw;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected acks and RAM beats,
// a negedge monitor pops and compares them. Honours ARB_MISALIGN_CHK_EN.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req = 1'b0;
  logic [7:0]  i_addr = 8'h00;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = SZ_WORD;
  logic [7:0]  d_addr = 8'h00;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        ram_en, ram_rw;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
`ifdef ARB_MISALIGN_CHK_EN
  logic        d_err;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
`ifdef ARB_MISALIGN_CHK_EN
    .d_err(d_err),
`endif
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Byte RAM model, preloaded with its own address; reset does not clear it.
  logic [7:0] mem [256];
  assign ram_rdata = mem[ram_addr];
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a);
    forever begin
      @(posedge clk);
      if (ram_en && ram_rw) mem[ram_addr] = ram_wdata;
    end
  end

  typedef struct { bit is_d; logic [31:0] rdata; bit err; } exp_t;
  typedef struct { logic [7:0] addr; bit rw; logic [7:0] wdata; } beat_t;
  exp_t  sb_q[$];
  beat_t bq[$];
  exp_t  me;
  beat_t mb;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_beats(input logic [7:0] base, input int k, input bit rw,
                            input logic [31:0] wd);
    beat_t b;
    for (int j = 0; j < k; j++) begin
      b.addr  = base + 8'(j);
      b.rw    = rw;
      b.wdata = wd[8*(k-1-j) +: 8];
      bq.push_back(b);
    end
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] rd, input bit err);
    exp_t e;
    e.is_d = is_d; e.rdata = rd; e.err = err;
    sb_q.push_back(e);
  endtask

  // Counts negedges from the request drive until the port's ack is seen.
  task automatic wait_ack(input bit is_d, output int lat);
    lat = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (is_d ? d_ack : i_ack) return;
    end
    n_tests++; n_fail++;
    $display("FAIL ack_timeout: port %0d got no ack expected ack within 40 cycles", is_d);
    lat = -1;
  endtask

  task automatic d_txn(input bit rw, input logic [1:0] sz, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    @(negedge clk);
    d_rw = rw; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
    push_exp(1'b1, exp_rd, 1'b0);
    push_beats(a, int'(beat_cnt(sz)), rw, wd);
    wait_ack(1'b1, lat);
    d_req = 1'b0;
    chk("d_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic i_txn(input logic [7:0] a, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    @(negedge clk);
    i_addr = a; i_req = 1'b1;
    push_exp(1'b0, exp_rd, 1'b0);
    push_beats(a, 4, 1'b0, 32'h0);
    wait_ack(1'b0, lat);
    i_req = 1'b0;
    chk("i_latency", 32'(lat), 32'(exp_lat));
  endtask

  // Monitor: every RAM beat and every ack is matched against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ram_en) begin
        if (bq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got ram_en at addr %h expected no beat", ram_addr);
        end else begin
          mb = bq.pop_front();
          chk("beat_addr", 32'(ram_addr), 32'(mb.addr));
          chk("beat_rw", 32'(ram_rw), 32'(mb.rw));
          if (mb.rw) chk("beat_wdata", 32'(ram_wdata), 32'(mb.wdata));
        end
      end else begin
        chk("rw_outside_beat", 32'(ram_rw), 32'h0);
      end
      if (i_ack || d_ack) begin
        chk("ack_exclusive", 32'(i_ack & d_ack), 32'h0);
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ack: got i_ack=%0d d_ack=%0d expected none", i_ack, d_ack);
        end else begin
          me = sb_q.pop_front();
          chk("ack_port", 32'(d_ack), 32'(me.is_d));
          chk("ack_rdata", me.is_d ? d_rdata : i_rdata, me.rdata);
`ifdef ARB_MISALIGN_CHK_EN
          chk("ack_err", 32'(d_err), 32'(me.err));
`endif
        end
      end
    end
  end

  initial begin
    int  lat;
    bit  found;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_rw", 32'(ram_rw), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_acks", 32'({i_ack, d_ack}), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention after reset: data, then instruction, then data again.
    @(negedge clk);
    d_rw = 1'b0; d_size = SZ_WORD; d_addr = 8'h04; d_req = 1'b1;
    i_addr = 8'h08; i_req = 1'b1;
    push_exp(1'b1, 32'h04050607, 1'b0);
    push_exp(1'b0, 32'h08090A0B, 1'b0);
    push_exp(1'b1, 32'h00000005, 1'b0);
    push_beats(8'h04, 4, 1'b0, 32'h0);
    push_beats(8'h08, 4, 1'b0, 32'h0);
    push_beats(8'h05, 1, 1'b0, 32'h0);
    wait_ack(1'b1, lat);
    d_size = SZ_BYTE; d_addr = 8'h05;
    wait_ack(1'b0, lat);
    i_req = 1'b0;
    wait_ack(1'b1, lat);
    d_req = 1'b0;

    i_txn(8'h10, 32'h10111213, 5);

    d_txn(1'b1, SZ_WORD, 8'h20, 32'hDEADBEEF, 32'h00000005, 5);
    chk("mem20", 32'(mem[8'h20]), 32'hDE);
    chk("mem21", 32'(mem[8'h21]), 32'hAD);
    chk("mem22", 32'(mem[8'h22]), 32'hBE);
    chk("mem23", 32'(mem[8'h23]), 32'hEF);
    d_txn(1'b0, SZ_HALF, 8'h22, 32'h0, 32'h0000BEEF, 3);

    d_txn(1'b1, SZ_HALF, 8'h30, 32'h00001234, 32'h0000BEEF, 3);
    d_txn(1'b1, SZ_BYTE, 8'h31, 32'h000000A5, 32'h0000BEEF, 2);
    chk("mem30", 32'(mem[8'h30]), 32'h12);
    chk("mem31", 32'(mem[8'h31]), 32'hA5);
    chk("mem32", 32'(mem[8'h32]), 32'h32);

`ifdef ARB_MISALIGN_CHK_EN
    @(negedge clk);
    d_rw = 1'b0; d_size = SZ_WORD; d_addr = 8'hFE; d_req = 1'b1;
    push_exp(1'b1, 32'h0000BEEF, 1'b1);
    wait_ack(1'b1, lat);
    d_req = 1'b0;
    chk("mis_latency", 32'(lat), 32'd1);
    @(negedge clk);
    chk("mis_err_pulse", 32'(d_err), 32'h0);
`else
    d_txn(1'b0, SZ_WORD, 8'hFE, 32'h0, 32'hFEFF0001, 5);
`endif
    chk("i_rdata_hold", i_rdata, 32'h10111213);

    // Reset during the third beat of a word write.
    @(negedge clk);
    d_rw = 1'b1; d_size = SZ_WORD; d_addr = 8'h40; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
    push_beats(8'h40, 4, 1'b1, 32'hCAFEF00D);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ram_en && ram_addr == 8'h42) found = 1'b1;
    end
    chk("reach_beat2", 32'(found), 32'h1);
    #1 rst_n = 1'b0;
    void'(bq.pop_back());
    d_req = 1'b0;
    #1;
    chk("abort_ram_en", 32'(ram_en), 32'h0);
    chk("abort_acks", 32'({i_ack, d_ack}), 32'h0);
    chk("abort_d_rdata", d_rdata, 32'h0);
    chk("abort_i_rdata", i_rdata, 32'h0);
    chk("abort_ram_addr", 32'(ram_addr), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mem40", 32'(mem[8'h40]), 32'hCA);
    chk("mem41", 32'(mem[8'h41]), 32'hFE);
    chk("mem42", 32'(mem[8'h42]), 32'h42);
    chk("mem43", 32'(mem[8'h43]), 32'h43);

    // Last grant returns to instruction on reset, so data wins again.
    @(negedge clk);
    d_rw = 1'b0; d_size = SZ_BYTE; d_addr = 8'h50; d_req = 1'b1;
    i_addr = 8'h60; i_req = 1'b1;
    push_exp(1'b1, 32'h00000050, 1'b0);
    push_exp(1'b0, 32'h60616263, 1'b0);
    push_beats(8'h50, 1, 1'b0, 32'h0);
    push_beats(8'h60, 4, 1'b0, 32'h0);
    wait_ack(1'b1, lat);
    d_req = 1'b0;
    wait_ack(1'b0, lat);
    i_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    chk("beats_drained", 32'(bq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
